// File: rtl/regfile_scoreboard.sv
// Register file (x0 = 0) with per-register pending-write counters for RAW/WAW decode stalls.
// Optional feature macro: RF_BYPASS_EN (write-through read bypass and hazard exemption).

module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ID_RegWrite,
    input  logic [4:0]      ID_RD,
    input  logic [XLEN-1:0] ID_RegWriteData,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [4:0]      issue_rd,
    input  logic            kill_valid,
    input  logic [4:0]      kill_rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            stall
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [XLEN-1:0]   r_regs [0:31];
    logic [PEND_W-1:0] r_pend [0:31];

    logic [PEND_W-1:0] w_pend_rs1;
    logic [PEND_W-1:0] w_pend_rs2;
    logic [PEND_W-1:0] w_pend_ird;
    logic              w_byp_rs1;
    logic              w_byp_rs2;
    logic              w_hazard_rs1;
    logic              w_hazard_rs2;
    logic              w_ird_dec;
    logic              w_full;
    logic              w_stall;
    logic              w_issue_fire;
    logic [PEND_W:0]   w_pend_up   [0:31];
    logic [PEND_W:0]   w_dec_cnt   [0:31];
    logic [PEND_W-1:0] w_pend_next [0:31];
    logic [31:0]       w_underflow;

    assign w_pend_rs1 = (rs1_addr == 5'd0) ? '0 : r_pend[rs1_addr];
    assign w_pend_rs2 = (rs2_addr == 5'd0) ? '0 : r_pend[rs2_addr];
    assign w_pend_ird = (issue_rd == 5'd0) ? '0 : r_pend[issue_rd];

`ifdef RF_BYPASS_EN
    // A write retiring this cycle is forwarded straight to the matching read port.
    assign w_byp_rs1 = ID_RegWrite && (ID_RD == rs1_addr) && (rs1_addr != 5'd0);
    assign w_byp_rs2 = ID_RegWrite && (ID_RD == rs2_addr) && (rs2_addr != 5'd0);
`else
    assign w_byp_rs1 = 1'b0;
    assign w_byp_rs2 = 1'b0;
`endif

    assign w_hazard_rs1 = rs1_used && (rs1_addr != 5'd0) && (w_pend_rs1 != '0)
                          && !(w_byp_rs1 && (w_pend_rs1 == PEND_W'(1)));
    assign w_hazard_rs2 = rs2_used && (rs2_addr != 5'd0) && (w_pend_rs2 != '0)
                          && !(w_byp_rs2 && (w_pend_rs2 == PEND_W'(1)));

    // A saturated counter can still accept an issue if a retire/kill frees a slot this cycle.
    assign w_ird_dec = (ID_RegWrite && (ID_RD == issue_rd))
                       || (kill_valid && (kill_rd == issue_rd));
    assign w_full    = issue_valid && issue_we && (issue_rd != 5'd0)
                       && (w_pend_ird == PEND_MAX) && !w_ird_dec;

    assign w_stall      = !rst && (w_hazard_rs1 || w_hazard_rs2 || w_full);
    assign stall        = w_stall;
    assign w_issue_fire = issue_valid && issue_we && !w_stall;

    assign rs1_data = (rst || (rs1_addr == 5'd0)) ? '0
                      : (w_byp_rs1 ? ID_RegWriteData : r_regs[rs1_addr]);
    assign rs2_data = (rst || (rs2_addr == 5'd0)) ? '0
                      : (w_byp_rs2 ? ID_RegWriteData : r_regs[rs2_addr]);

    always_comb begin
        // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
        w_pend_up[0]   = '0;
        w_dec_cnt[0]   = '0;
        w_pend_next[0] = '0;
        w_underflow    = '0;
        for (int r = 1; r < 32; r++) begin
            w_pend_up[r]   = {1'b0, r_pend[r]}
                             + (PEND_W+1)'(w_issue_fire && (issue_rd == 5'(r)));
            w_dec_cnt[r]   = (PEND_W+1)'(ID_RegWrite && (ID_RD == 5'(r)))
                             + (PEND_W+1)'(kill_valid && (kill_rd == 5'(r)));
            w_underflow[r] = (w_pend_up[r] < w_dec_cnt[r]);
            w_pend_next[r] = w_underflow[r] ? '0 : PEND_W'(w_pend_up[r] - w_dec_cnt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register array is architecturally cleared on reset, so it cannot map to a RAM macro.
            for (int r = 0; r < 32; r++) begin
                r_regs[r] <= '0;
                r_pend[r] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
            if (ID_RegWrite && (ID_RD != 5'd0)) begin
                r_regs[ID_RD] <= ID_RegWriteData;
            end
            for (int r = 1; r < 32; r++) begin
                r_pend[r] <= w_pend_next[r];
            end
        end
    end

    // Retiring or killing a writer that was never issued is a protocol error upstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_underflow == '0);
        end
    end

endmodule
